// File: rtl/sideband_egress.sv
// sideband_egress: pops frame descriptors and streams frames from the frame buffer as AXI-stream.
// Define SIDEBAND_EGRESS_STATS_EN to add frame/byte/desync counters. Rev 1.0
`default_nettype none

`ifndef AXIS_DEST_WIDTH
`define AXIS_DEST_WIDTH 4
`endif

module sideband_egress #(
  parameter int ADDR_WIDTH = 11,
  parameter int DEST_WIDTH = `AXIS_DEST_WIDTH,
  parameter int SB_WIDTH   = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sb_empty,
  output logic                  sb_ren,
  input  logic [SB_WIDTH-1:0]   sb_rdata,
  output logic                  fb_ren,
  output logic [ADDR_WIDTH-1:0] fb_raddr,
  input  logic [8:0]            fb_rdata,
  output logic [ADDR_WIDTH:0]   fb_rptr,
  output logic [7:0]            m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [DEST_WIDTH-1:0] m_tdest,
  output logic                  desync
`ifdef SIDEBAND_EGRESS_STATS_EN
  ,
  output logic [31:0]           stat_frames,
  output logic [31:0]           stat_bytes,
  output logic [15:0]           stat_desync
`endif
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]            r_state;
  logic                  r_armed;
  logic [PW-1:0]         r_rp;
  logic [PW-1:0]         r_fa;
  logic [PW-1:0]         r_end;
  logic [PW-1:0]         r_rptr;
  logic                  r_inflight;
  logic                  r_stop;
  logic                  r_desync;
  logic [DEST_WIDTH-1:0] r_dest;
  logic [8:0]            r_buf [2];
  logic                  r_wp;
  logic                  r_rdp;
  logic [1:0]            r_cnt;

  logic [PW-1:0]         w_start;
  logic [DEST_WIDTH-1:0] w_dest;
  logic                  w_last_ret;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_credit;
  logic                  w_desync_set;
  logic                  w_unused_sb;

  assign w_start      = sb_rdata[ADDR_WIDTH+DEST_WIDTH:DEST_WIDTH];
  assign w_dest       = sb_rdata[DEST_WIDTH-1:0];
  assign w_unused_sb  = ^sb_rdata[SB_WIDTH-1:ADDR_WIDTH+DEST_WIDTH+1];
  assign w_desync_set = (r_state == ST_LOAD) && (w_start != r_rptr);

  assign w_push     = r_inflight & ~r_stop;
  assign w_last_ret = w_push & fb_rdata[8];
  assign w_pop      = m_tvalid & m_tready;
  // A slot freed by this cycle's pop may be re-claimed; keeps 1 byte/cycle with a 2-deep buffer.
  assign w_credit   = ({1'b0, r_cnt} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

  assign sb_ren   = r_armed & (r_state == ST_IDLE) & ~sb_empty;
  assign fb_ren   = (r_state == ST_STREAM) & ~r_stop & ~w_last_ret & w_credit;
  assign fb_raddr = r_rp[ADDR_WIDTH-1:0];
  assign fb_rptr  = r_rptr;
  assign m_tvalid = (r_cnt != 2'd0);
  assign m_tdata  = r_buf[r_rdp][7:0];
  assign m_tlast  = m_tvalid & r_buf[r_rdp][8];
  assign m_tdest  = r_dest;
  assign desync   = r_desync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_armed    <= 1'b0;
      r_rp       <= '0;
      r_fa       <= '0;
      r_end      <= '0;
      r_rptr     <= '0;
      r_inflight <= 1'b0;
      r_stop     <= 1'b0;
      r_desync   <= 1'b0;
      r_dest     <= '0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_wp       <= 1'b0;
      r_rdp      <= 1'b0;
      r_cnt      <= 2'd0;
    end else begin
      r_armed    <= 1'b1;
      r_desync   <= 1'b0;
      r_inflight <= fb_ren;
      if (fb_ren) begin
        r_fa <= r_rp;
        r_rp <= r_rp + PTR_ONE;
      end
      if (w_push) begin
        r_buf[r_wp] <= fb_rdata;
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_rdp <= ~r_rdp;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      // Words fetched after the last byte are dropped and the pointer rewound past it.
      if (w_last_ret) begin
        r_stop <= 1'b1;
        r_end  <= r_fa + PTR_ONE;
        r_rp   <= r_fa + PTR_ONE;
      end
      case (r_state)
        ST_IDLE: begin
          if (sb_ren) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_dest   <= w_dest;
          r_rp     <= w_start;
          r_stop   <= 1'b0;
          r_desync <= w_desync_set;
          r_state  <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_pop && m_tlast) begin
            r_rptr  <= r_end;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SIDEBAND_EGRESS_STATS_EN
  logic [31:0] r_stat_frames;
  logic [31:0] r_stat_bytes;
  logic [15:0] r_stat_desync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_frames <= '0;
      r_stat_bytes  <= '0;
      r_stat_desync <= '0;
    end else begin
      if (w_pop) r_stat_bytes <= r_stat_bytes + 32'd1;
      if (w_pop && m_tlast) r_stat_frames <= r_stat_frames + 32'd1;
      if (w_desync_set && (r_stat_desync != 16'hFFFF)) r_stat_desync <= r_stat_desync + 16'd1;
    end
  end

  assign stat_frames = r_stat_frames;
  assign stat_bytes  = r_stat_bytes;
  assign stat_desync = r_stat_desync;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sideband_egress.sv
// tb_sideband_egress: scoreboard bench with models of the sideband FIFO and the frame buffer.
`default_nettype none

module tb_sideband_egress;

  localparam int AW  = 11;
  localparam int DW  = 4;
  localparam int SBW = 20;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           sb_empty;
  logic           sb_ren;
  logic [SBW-1:0] sb_rdata = '0;
  logic           fb_ren;
  logic [AW-1:0]  fb_raddr;
  logic [8:0]     fb_rdata = '0;
  logic [AW:0]    fb_rptr;
  logic [7:0]     m_tdata;
  logic           m_tvalid;
  logic           m_tready = 1'b1;
  logic           m_tlast;
  logic [DW-1:0]  m_tdest;
  logic           desync;
`ifdef SIDEBAND_EGRESS_STATS_EN
  logic [31:0]    stat_frames;
  logic [31:0]    stat_bytes;
  logic [15:0]    stat_desync;
`endif

  sideband_egress #(.ADDR_WIDTH(AW), .DEST_WIDTH(DW), .SB_WIDTH(SBW)) dut (
    .clk(clk), .reset_n(reset_n), .sb_empty(sb_empty), .sb_ren(sb_ren), .sb_rdata(sb_rdata),
    .fb_ren(fb_ren), .fb_raddr(fb_raddr), .fb_rdata(fb_rdata), .fb_rptr(fb_rptr),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tdest(m_tdest), .desync(desync)
`ifdef SIDEBAND_EGRESS_STATS_EN
    , .stat_frames(stat_frames), .stat_bytes(stat_bytes), .stat_desync(stat_desync)
`endif
  );

  always #5 clk = ~clk;

  // Sideband FIFO and frame buffer models
  logic [SBW-1:0] sbq [16];
  int             sb_head = 0;
  int             sb_tail = 0;
  logic [8:0]     mem [2048];

  assign sb_empty = (sb_head == sb_tail);

  always @(posedge clk) begin
    if (sb_ren) begin
      sb_rdata <= sbq[sb_head % 16];
      sb_head  <= sb_head + 1;
    end
    if (fb_ren) fb_rdata <= mem[fb_raddr];
  end

  typedef struct packed {
    logic [7:0]    d;
    logic          l;
    logic [DW-1:0] t;
  } beat_t;

  beat_t         exp_q[$];
  int            end_q[$];
  logic [AW-1:0] raddr_log[$];
  int checks = 0;
  int errors = 0;
  int beats = 0;
  int sbren_cnt = 0;
  int desync_cnt = 0;
  int cyc = 0;
  int model_rptr = 0;
  int gap_from = 0;
  bit gap_en = 1'b0;
  bit gap_arm = 1'b0;
  bit rand_en = 1'b0;
  bit prev_stall = 1'b0;
  beat_t prev_beat;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every accepted beat against the scoreboard
  always @(negedge clk) begin
    beat_t e;
    int    gap;
    cyc++;
    if (!reset_n) begin
      prev_stall = 1'b0;
      gap_arm    = 1'b0;
      model_rptr = 0;
      exp_q.delete();
      end_q.delete();
    end else begin
      if (sb_ren) sbren_cnt++;
      if (desync) desync_cnt++;
      if (fb_ren) begin
        raddr_log.push_back(fb_raddr);
        if (gap_arm) begin
          gap = cyc - gap_from - 1;
          checks++;
          if (gap > 3) begin
            errors++;
            $display("FAIL gap: got %0d cycles, expected <= 3", gap);
          end
          gap_arm = 1'b0;
        end
      end
      if (prev_stall) check("hold", {m_tvalid, m_tdata, m_tlast, m_tdest}, {1'b1, prev_beat});
      if (m_tvalid && m_tready) begin
        beats++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat: got unexpected 0x%0h, expected none", {m_tdata, m_tlast, m_tdest});
        end else begin
          e = exp_q.pop_front();
          check("beat", {m_tdata, m_tlast, m_tdest}, e);
        end
        if (m_tlast) begin
          check("rptr_at_tlast", fb_rptr, model_rptr);
          if (end_q.size() != 0) model_rptr = end_q.pop_front();
          if (gap_en && m_tdest == 4'd1) begin
            gap_arm  = 1'b1;
            gap_from = cyc;
          end
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tdata, m_tlast, m_tdest};
    end
  end

  // Ready driver: constant high or a random 50% pattern
  initial begin
    forever begin
      @(posedge clk);
      #2;
      m_tready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SBW-1:0] mk_desc(input int dest, input int start);
    logic [SBW-1:0] d;
    d = '0;
    d[DW-1:0]    = dest[DW-1:0];
    d[AW+DW:DW]  = start[AW:0];
    return d;
  endfunction

  task automatic load_frame(input int start, input int len, input int b0, input int dest);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = 8'(b0 + i);
      b.l = (i == len - 1);
      b.t = DW'(dest);
      mem[(start + i) % 2048] = {b.l, b.d};
      exp_q.push_back(b);
    end
    end_q.push_back((start + len) % 4096);
    sbq[sb_tail % 16] = mk_desc(dest, start);
    sb_tail++;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid || !sb_empty) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got timeout with %0d beats pending, expected 0", nm, exp_q.size());
    end
    tick();
    tick();
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_sb_ren"}, sb_ren, 0);
    check({nm, "_fb_ren"}, fb_ren, 0);
    check({nm, "_fb_rptr"}, fb_rptr, 0);
    check({nm, "_tvalid"}, m_tvalid, 0);
    check({nm, "_tlast"}, m_tlast, 0);
    check({nm, "_tdest"}, m_tdest, 0);
    check({nm, "_desync"}, desync, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    int s0;
    int d0;
    int b0;
    int n;
    int lat;
    int exp_a [4];
    exp_a = '{2046, 2047, 0, 1};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();
    tick();

    // 64-byte frame, ready always high
    s0 = sbren_cnt;
    d0 = desync_cnt;
    load_frame(0, 64, 'h10, 2);
    lat = 0;
    while (!m_tvalid && lat < 20) begin
      tick();
      lat++;
    end
    check("first_valid_latency", lat, 4);
    wait_drain("t1");
    check("t1_rptr", fb_rptr, 64);
    check("t1_sb_ren_once", sbren_cnt - s0, 1);
    check("t1_no_desync", desync_cnt - d0, 0);

    // Same frame under random back-pressure
    rand_en = 1'b1;
    load_frame(64, 64, 'h10, 2);
    wait_drain("t2");
    rand_en = 1'b0;
    tick();
    check("t2_rptr", fb_rptr, 128);

    // Back-to-back descriptors
    gap_en = 1'b1;
    load_frame(128, 3, 'hA0, 1);
    load_frame(131, 1, 'hB0, 3);
    wait_drain("t3");
    gap_en = 1'b0;
    check("t3_rptr", fb_rptr, 132);

    // Pointer wrap
    d0 = desync_cnt;
    raddr_log.delete();
    load_frame(2046, 4, 'h61, 5);
    wait_drain("t4");
    check("t4_raddr_count", raddr_log.size(), 4);
    for (int i = 0; i < 4 && i < raddr_log.size(); i++) check("t4_raddr", raddr_log[i], exp_a[i]);
    check("t4_rptr", fb_rptr, 'h802);
    check("t4_desync", desync_cnt - d0, 1);

    // Reset in the middle of a frame
    load_frame(256, 20, 'h20, 6);
    b0 = beats;
    n = 0;
    while (beats - b0 < 5 && n < 200) begin
      tick();
      n++;
    end
    check("t5_reached_beat5", (beats - b0 >= 5), 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick();
    tick();
    reset_n = 1'b1;
    tick();
`ifdef SIDEBAND_EGRESS_STATS_EN
    check("t5_stat_bytes_cleared", stat_bytes, 0);
`endif

    // fb_rptr=0 with descriptor start=10
    d0 = desync_cnt;
    raddr_log.delete();
    load_frame(10, 3, 'h70, 7);
    wait_drain("t6");
    check("t6_desync", desync_cnt - d0, 1);
    check("t6_first_raddr", (raddr_log.size() != 0) ? int'(raddr_log[0]) : -1, 10);
    check("t6_rptr", fb_rptr, 13);
`ifdef SIDEBAND_EGRESS_STATS_EN
    check("t6_stat_desync", stat_desync, 1);
    check("t6_stat_frames", stat_frames, 1);
    check("t6_stat_bytes", stat_bytes, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sideband_egress.md
Name: sideband_egress

Overview:
- Downstream consumer of the sideband FIFO. Pops one accepted-frame descriptor at a time and streams that frame out of the frame buffer as AXI-stream, routed by the stored destination.
- Each descriptor holds the destination and the frame start pointer.
- Returns consumed frame-buffer space by advancing a read pointer that the frame-buffer writer uses for its full check.

Parameters:
- ADDR_WIDTH, 11: frame buffer address width; pointers carry one extra wrap bit.
- DEST_WIDTH, `AXIS_DEST_WIDTH: destination field width.
- SB_WIDTH, 20: sideband word width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- sb_empty  in  1  sideband FIFO empty
- sb_ren  out  1  sideband FIFO read strobe
- sb_rdata  in  SB_WIDTH  descriptor, valid the cycle after sb_ren; [DEST_WIDTH-1:0] dest, [ADDR_WIDTH+DEST_WIDTH:DEST_WIDTH] start pointer, upper bits ignored
- fb_ren  out  1  frame buffer read enable
- fb_raddr  out  ADDR_WIDTH  frame buffer read address
- fb_rdata  in  9  {last, byte}, valid the cycle after fb_ren
- fb_rptr  out  ADDR_WIDTH+1  released read pointer, including wrap bit
- m_tdata  out  8  egress byte
- m_tvalid  out  1  egress valid
- m_tready  in  1  egress ready
- m_tlast  out  1  final byte of frame
- m_tdest  out  DEST_WIDTH  frame destination, constant across a frame
- desync  out  1  one-cycle pulse: descriptor start pointer differed from fb_rptr

Behaviour:
- Reset (async assert, sync deassert):
  - Outputs: sb_ren=0, fb_ren=0, fb_rptr=0, m_tvalid=0, m_tlast=0, m_tdest=0, desync=0.
  - Internal state: FSM goes to IDLE, skid buffer cleared.
- FSM states:
  - IDLE: if ~sb_empty, assert sb_ren for exactly 1 cycle and go to LOAD.
  - LOAD: latch dest and start pointer from sb_rdata.
    - Load the internal read pointer rp with the start pointer.
    - If start != fb_rptr, pulse desync; the start pointer wins.
    - Go to STREAM.
  - STREAM: issue fb_ren with fb_raddr=rp[ADDR_WIDTH-1:0], then rp++.
    - rp is ADDR_WIDTH+1 bits and wraps naturally, with the wrap bit toggling.
    - Reads are issued only while the 2-entry output skid buffer has a free slot, counting reads in flight.
    - Stop issuing once a returned word has last=1. Discard any speculatively fetched word that follows it.
    - Rewind rp to the address after the last byte.
  - DONE: entered when the byte with m_tlast is accepted (m_tvalid & m_tready). On the same edge fb_rptr <= address after last byte. Then go to IDLE.
- Throughput and latency:
  - 1 byte/cycle sustained while m_tready=1.
  - First m_tvalid appears 4 cycles after sb_empty falls (IDLE -> LOAD -> fetch -> data -> out).
  - Inter-frame gap ≤ 3 cycles.
- AXI-stream rules:
  - m_tvalid, once high, holds and keeps m_tdata/m_tlast/m_tdest stable until accepted.
  - m_tdest updates only between frames.
  - No combinational path from m_tready to m_tvalid or fb_ren beyond the skid-buffer occupancy.
- Boundaries:
  - sb_empty rising mid-frame has no effect.
  - A 1-byte frame (last on first word) gives a single beat with m_tlast=1.
  - Pointer wrap from 2^ADDR_WIDTH-1 to 0 is seamless.
  - m_tready low for any duration loses and duplicates no bytes.
  - fb_rptr never passes a byte that has not been accepted.
  - Reset mid-frame abandons the frame and re-zeros fb_rptr.
- Invariant: sb_ren never fires outside IDLE.

Optional Feature:
- Macro SIDEBAND_EGRESS_STATS_EN.
- When defined, add outputs:
  - stat_frames (32b): +1 per accepted tlast beat.
  - stat_bytes (32b): +1 per accepted beat.
  - stat_desync (16b): +1 per desync pulse, saturating.
  - All three are cleared by reset; the 32b counters wrap.
- When undefined, these ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- Frame bytes 0x10..0x4F (64B, last on 0x4F) at addr 0, descriptor {dest=2, start=0}, m_tready=1 -> 64 beats with m_tdest=2 and tlast on beat 64; fb_rptr=64 the cycle after the tlast accept; sb_ren pulsed exactly once.
- Same frame with m_tready toggled by a random 50% pattern -> identical byte sequence; m_tvalid never drops before accept; fb_rptr=64 only after the tlast accept.
- Two back-to-back descriptors {dest=1,start=0,len=3} and {dest=3,start=3,len=1} -> 3 beats dest=1 then 1 beat dest=3 with tlast; gap ≤3 cycles; fb_rptr=4.
- Frame starting at 2046 of length 4 (ADDR_WIDTH=11) -> fb_raddr sequence 2046, 2047, 0, 1; final fb_rptr=0x802 (wrap bit set).
- fb_rptr=0, descriptor start=10 -> desync pulses 1 cycle, bytes read from addr 10, stats build reports stat_desync=1.
- Deassert reset_n mid-frame at beat 5 -> all outputs return to reset values immediately; after release, the next descriptor streams correctly from its start pointer.
